// File: rtl/graph_col_buf_ctrl.sv
// Column-height buffer for the line-graph interpolator: a scrolling shadow buffer is loaded through
// valid/ready and committed to col_hs on each vblank rising edge. Optional build macro: GRAPH_CLAMP_EN.
module graph_col_buf_ctrl #(
   parameter int N_COLS = 20,
   parameter int MAX_H  = 239
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic                          clr,
   input  logic                          vblank,
   output logic [8*N_COLS-1:0]           col_hs,
   output logic                          line_en,
   output logic [$clog2(N_COLS+1)-1:0]   pend_cnt
`ifdef GRAPH_CLAMP_EN
   ,
   output logic                          clamp_hit
`endif
);

   localparam int            CW   = $clog2(N_COLS + 1);
   localparam int            BW   = 8 * N_COLS;
   localparam logic [CW-1:0] FULL = CW'(N_COLS);

   if (MAX_H < 0 || MAX_H > 255) begin : g_max_h_chk
      $error("MAX_H must fit in an 8-bit column height");
   end

   typedef enum logic {ACCEPT = 1'b0, COMMIT = 1'b1} state_t;

   state_t          state_q, state_d;
   logic            vblank_d_q;
   logic [BW-1:0]   shadow_q, shadow_d;
   logic [BW-1:0]   col_hs_q, col_hs_d;
   logic            line_en_q, line_en_d;
   logic [CW-1:0]   pend_q, pend_d;
   logic [CW-1:0]   fill_q, fill_d;
   logic            clr_pend_q, clr_pend_d;
   logic            vb_rise;
   logic            accept;
   logic [7:0]      sample;

   assign vb_rise = vblank & ~vblank_d_q;
   assign accept  = s_valid & s_ready;

`ifdef GRAPH_CLAMP_EN
   logic clamp_hit_q, clamp_hit_d;
   logic over_h;

   assign over_h    = s_data > 8'(MAX_H);
   assign sample    = over_h ? 8'(MAX_H) : s_data;
   assign clamp_hit = clamp_hit_q;
`else
   assign sample = s_data;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ACCEPT;
      else     state_q <= state_d;
   end

   // A commit needs something to show: new samples, or a clear that must reach the display.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACCEPT:  if (vb_rise && (pend_q != '0 || clr_pend_q)) state_d = COMMIT;
         COMMIT:  state_d = ACCEPT;
         default: state_d = ACCEPT;
      endcase
   end

   always_comb begin
      s_ready = (state_q == ACCEPT) && (pend_q < FULL) && !vb_rise && !clr;
   end

   always_comb begin
      shadow_d   = shadow_q;
      col_hs_d   = col_hs_q;
      line_en_d  = line_en_q;
      pend_d     = pend_q;
      fill_d     = fill_q;
      clr_pend_d = clr_pend_q;
`ifdef GRAPH_CLAMP_EN
      clamp_hit_d = clamp_hit_q;
`endif
      if (state_q == COMMIT) begin
         col_hs_d   = shadow_q;
         line_en_d  = (fill_q == FULL);
         pend_d     = '0;
         clr_pend_d = 1'b0;
      end else if (clr) begin
         shadow_d   = '0;
         pend_d     = '0;
         fill_d     = '0;
         clr_pend_d = 1'b1;
`ifdef GRAPH_CLAMP_EN
         clamp_hit_d = 1'b0;
`endif
      end else if (accept) begin
         // Column 0 falls off the low end; the new sample enters at column N_COLS-1.
         shadow_d = {sample, shadow_q[BW-1:8]};
         pend_d   = pend_q + CW'(1);
         if (fill_q != FULL) fill_d = fill_q + CW'(1);
`ifdef GRAPH_CLAMP_EN
         if (over_h) clamp_hit_d = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vblank_d_q <= 1'b0;
         shadow_q   <= '0;
         col_hs_q   <= '0;
         line_en_q  <= 1'b0;
         pend_q     <= '0;
         fill_q     <= '0;
         clr_pend_q <= 1'b0;
      end else begin
         vblank_d_q <= vblank;
         shadow_q   <= shadow_d;
         col_hs_q   <= col_hs_d;
         line_en_q  <= line_en_d;
         pend_q     <= pend_d;
         fill_q     <= fill_d;
         clr_pend_q <= clr_pend_d;
      end
   end

`ifdef GRAPH_CLAMP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) clamp_hit_q <= 1'b0;
      else     clamp_hit_q <= clamp_hit_d;
   end
`endif

   assign col_hs   = col_hs_q;
   assign line_en  = line_en_q;
   assign pend_cnt = pend_q;

endmodule

// File: tb/tb_graph_col_buf_ctrl.sv
// Directed bench for graph_col_buf_ctrl (N_COLS=20, MAX_H=239) with hand-computed expected values.
module tb_graph_col_buf_ctrl;

   localparam int N  = 20;
   localparam int BW = 8 * N;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic          clr = 1'b0;
   logic          vblank = 1'b0;
   logic [BW-1:0] col_hs;
   logic          line_en;
   logic [4:0]    pend_cnt;
`ifdef GRAPH_CLAMP_EN
   logic          clamp_hit;
`endif

   int            n_vec = 0;
   int            n_err = 0;
   logic [BW-1:0] e;

   graph_col_buf_ctrl #(.N_COLS(N), .MAX_H(239)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .clr      (clr),
      .vblank   (vblank),
      .col_hs   (col_hs),
      .line_en  (line_en),
      .pend_cnt (pend_cnt)
`ifdef GRAPH_CLAMP_EN
      ,
      .clamp_hit(clamp_hit)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      s_valid = 1'b1;
      s_data  = d;
      tick();
      s_valid = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_col_hs", col_hs, '0);
      chk("rst_line_en", BW'(line_en), '0);
      chk("rst_pend", BW'(pend_cnt), '0);
      chk("rst_ready", BW'(s_ready), 1);
`ifdef GRAPH_CLAMP_EN
      chk("rst_clamp_hit", BW'(clamp_hit), '0);
`endif
      tick();

      // Partial frame: 10, 20, 30 then vblank rise.
      push(8'd10);
      push(8'd20);
      push(8'd30);
      chk("part_pend3", BW'(pend_cnt), 3);
      vblank = 1'b1;
      #1;
      chk("part_ready_vbrise", BW'(s_ready), '0);
      tick();
      chk("part_commit_cycle_col", col_hs, '0);
      chk("part_commit_cycle_ready", BW'(s_ready), '0);
      tick();
      e = '0;
      e[159:152] = 8'd30;
      e[151:144] = 8'd20;
      e[143:136] = 8'd10;
      chk("part_col_hs", col_hs, e);
      chk("part_line_en", BW'(line_en), '0);
      chk("part_pend0", BW'(pend_cnt), '0);
      chk("part_ready_after", BW'(s_ready), 1);
      // Held vblank: a pending sample must not commit until vblank falls and rises again.
      push(8'd40);
      tick();
      tick();
      tick();
      chk("held_vb_col_hs", col_hs, e);
      chk("held_vb_pend", BW'(pend_cnt), 1);
      vblank = 1'b0;
      tick();

      // Asynchronous reset mid-run, no clock edge needed.
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_col_hs", col_hs, '0);
      chk("async_rst_line_en", BW'(line_en), '0);
      chk("async_rst_pend", BW'(pend_cnt), '0);
      rst = 1'b0;
      #1;
      chk("async_rst_ready", BW'(s_ready), 1);
      tick();

      // Full buffer and back-pressure.
      for (int i = 0; i < N; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(i + 1);
         #1;
         if (!s_ready) begin
            chk($sformatf("fill_ready_%0d", i), BW'(s_ready), 1);
         end
         tick();
      end
      n_vec++;
      s_data = 8'd21;
      #1;
      chk("full_ready_low", BW'(s_ready), '0);
      chk("full_pend20", BW'(pend_cnt), 20);
      tick();
      tick();
      chk("full_ready_held", BW'(s_ready), '0);
      chk("full_pend_held", BW'(pend_cnt), 20);
      vblank = 1'b1;
      tick();
      chk("full_commit_ready", BW'(s_ready), '0);
      tick();
      for (int i = 0; i < N; i++) e[8*i +: 8] = 8'(i + 1);
      chk("full_col_hs", col_hs, e);
      chk("full_line_en", BW'(line_en), 1);
      chk("full_pend0", BW'(pend_cnt), '0);
      chk("full_21st_ready", BW'(s_ready), 1);
      tick();
      s_valid = 1'b0;
      chk("full_21st_accepted", BW'(pend_cnt), 1);

      // Sample offered in the vb_rise cycle is not taken.
      vblank = 1'b0;
      tick();
      s_valid = 1'b1;
      s_data  = 8'd99;
      vblank  = 1'b1;
      #1;
      chk("coll_ready_vbrise", BW'(s_ready), '0);
      tick();
      s_valid = 1'b0;
      tick();
      for (int i = 0; i < N; i++) e[8*i +: 8] = 8'(i + 2);
      chk("coll_col_hs", col_hs, e);
      chk("coll_line_en", BW'(line_en), 1);
      chk("coll_pend0", BW'(pend_cnt), '0);

      // vb_rise with nothing pending: no COMMIT, display unchanged.
      vblank = 1'b0;
      tick();
      vblank = 1'b1;
      tick();
      chk("nocommit_ready", BW'(s_ready), 1);
      chk("nocommit_col_hs", col_hs, e);
      tick();
      chk("nocommit_col_hs2", col_hs, e);

      // Clear then vblank rise blanks the display.
      vblank = 1'b0;
      clr    = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'd77;
      #1;
      chk("clr_ready", BW'(s_ready), '0);
      tick();
      clr     = 1'b0;
      s_valid = 1'b0;
      chk("clr_pend0", BW'(pend_cnt), '0);
      vblank = 1'b1;
      tick();
      tick();
      chk("clr_col_hs", col_hs, '0);
      chk("clr_line_en", BW'(line_en), '0);

      // clr during COMMIT is ignored.
      vblank = 1'b0;
      tick();
      push(8'd5);
      push(8'd6);
      vblank = 1'b1;
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      e = '0;
      e[159:152] = 8'd6;
      e[151:144] = 8'd5;
      chk("clr_in_commit_col_hs", col_hs, e);
      chk("clr_in_commit_line_en", BW'(line_en), '0);
      chk("clr_in_commit_pend", BW'(pend_cnt), '0);
      vblank = 1'b0;
      tick();
      push(8'd7);
      vblank = 1'b1;
      tick();
      tick();
      e = '0;
      e[159:152] = 8'd7;
      e[151:144] = 8'd6;
      e[143:136] = 8'd5;
      chk("clr_in_commit_kept", col_hs, e);

      // Clamp behaviour on an over-height sample.
      vblank = 1'b0;
      tick();
      push(8'd250);
      vblank = 1'b1;
      tick();
      tick();
      e = '0;
`ifdef GRAPH_CLAMP_EN
      e[159:152] = 8'd239;
`else
      e[159:152] = 8'd250;
`endif
      e[151:144] = 8'd7;
      e[143:136] = 8'd6;
      e[135:128] = 8'd5;
      chk("clamp_col_hs", col_hs, e);
`ifdef GRAPH_CLAMP_EN
      chk("clamp_hit_set", BW'(clamp_hit), 1);
`endif

      // Reset during COMMIT abandons the commit.
      vblank = 1'b0;
      tick();
      push(8'd1);
      vblank = 1'b1;
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_commit_col_hs", col_hs, '0);
      chk("rst_commit_pend", BW'(pend_cnt), '0);
      vblank = 1'b0;
      rst    = 1'b0;
      tick();
      chk("rst_commit_col_hs_after", col_hs, '0);
      chk("rst_commit_line_en", BW'(line_en), '0);
      chk("rst_commit_ready", BW'(s_ready), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
